pixel_gen_pipe: RTL and testbench
=================================

Name: pixel_gen_pipe

Overview:
Parametrised, registered successor to the combinational VGA pixel generator. It has configurable cell size, counter width, colour depth and palette. It adds a two-stage output pipeline, a frame-counted blinking edit cursor, and an invert (theme) mode. It sits between the VGA timing/memory-fetch logic and the RGB output pins, and delays `valid` alongside the pixel so downstream sync alignment is explicit.

Parameters:
CNT_W, 10, width of h_cnt/v_cnt
CELL_LOG2, 5, log2 of square cell size in pixels (5 → 32x32 cells)
COLOR_W, 12, pixel colour width
BLINK_FRAMES, 30, frames per cursor blink half-period (≥1)
FG_COLOR, 12'hfff, glyph/ink colour (normal theme)
BG_COLOR, 12'h000, background colour (normal theme)
GRID_COLOR, 12'h333, cell border colour
CUR_BORDER_ON, 12'hccc, cursor-cell border colour when mem_pixel=1

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
valid  in  1  display-active from VGA timing
h_cnt  in  CNT_W  horizontal pixel index
v_cnt  in  CNT_W  vertical pixel index
frame_start  in  1  one-cycle pulse at start of each frame
enable_mouse_display  in  1  mouse sprite covers this pixel
mouse_pixel  in  COLOR_W  mouse sprite colour
enable_word_display  in  1  word layer enabled
word_pixel  in  1  word-layer bit
mem_pixel  in  1  edit-buffer bit at this pixel
editing  in  1  edit mode active
writing_x  in  CNT_W-CELL_LOG2  cursor cell column
writing_y  in  CNT_W-CELL_LOG2  cursor cell row
blink_en  in  1  1 = cursor blinks, 0 = always visible
invert  in  1  swap FG_COLOR/BG_COLOR for ink/background
pixel  out  COLOR_W  registered RGB
pixel_valid  out  1  valid delayed to match pixel

Behaviour:
- Reset (rst_n=0, async): pixel=0, pixel_valid=0, all pipeline registers 0, blink counter=0, blink_phase=1 (visible), editing_d=0.
- Latency: fixed 2 cycles. Inputs sampled at edge N appear on pixel/pixel_valid after edge N+1. Every input, including mouse and memory data, is sampled in the same cycle as its h_cnt/v_cnt.
- Stage 1 registers:
  - valid
  - border = (h_cnt[CELL_LOG2-1:0] is 0 or all-ones) OR (same for v_cnt)
  - cur_hit = editing & cursor_visible & (h_cnt[CNT_W-1:CELL_LOG2]==writing_x) & (v_cnt[CNT_W-1:CELL_LOG2]==writing_y)
  - mouse enable/colour, mem_pixel, word bit gated by enable_word_display, invert
- Stage 2 priority mux, registered:
  1. !valid → 0
  2. mouse → mouse_pixel
  3. cur_hit & border → mem ? CUR_BORDER_ON : GRID_COLOR
  4. cur_hit → mem ? ink : bg
  5. border → GRID_COLOR
  6. word → ink
  7. else → bg
- ink = invert ? BG_COLOR : FG_COLOR; bg = invert ? FG_COLOR : BG_COLOR. GRID and cursor border colours are not inverted.
- Blink:
  - cursor_visible = !blink_en | blink_phase.
  - On frame_start, counter increments. When counter==BLINK_FRAMES-1 and frame_start=1, counter→0 and blink_phase toggles.
  - Rising edge of editing (editing & !editing_d) forces counter=0, blink_phase=1. This takes priority over a simultaneous frame_start.
  - editing=0 leaves the counter running. The phase is irrelevant while editing=0.
- Counter width is clog2(BLINK_FRAMES); BLINK_FRAMES=1 toggles every frame.
- Blink state updates within a frame affect pixels from the next cycle on. Stage-1 sampling uses the current registered phase.
- Reset mid-frame clears the pipeline immediately. The first two outputs after release are 0/invalid.
- Cursor coordinates beyond the grid never match, so no cursor is drawn.

Test Plan:
1. Reset, then valid=1, h=40, v=40, all enables 0 → pixel 12'h000 and pixel_valid=1 exactly 2 cycles later. Outputs are 0 during reset.
2. Border: h=32, v=40 → 12'h333. h=63 → 12'h333. h=33 with word_pixel=1, enable_word_display=1 → 12'hfff. Same with invert=1 → 12'h000.
3. Cursor: editing=1, blink_en=0, writing=(1,1), h=32, v=40, mem_pixel=1 → 12'hccc. With mem=0 → 12'h333. h=40, mem=1 → 12'hfff.
4. Priority: mouse enabled with mouse_pixel=12'hf00 on the cursor border → 12'hf00. valid=0 with mouse enabled → 0.
5. Blink, BLINK_FRAMES=3, blink_en=1, editing rises: cursor visible for frame_start pulses 1–2, hidden after pulse 3 (interior pixel shows word/bg), visible again after pulse 6. Re-raising editing while hidden makes it visible next cycle.
6. Async reset asserted mid-stream between edges → pixel and pixel_valid go 0 immediately without a clock. Blink phase returns to visible.

Source files
------------

// File: rtl/pixel_gen_pipe_if.sv
// Pixel-generator bus: timing/fetch side drives the pixel request, the
// generator returns the registered colour and its delayed valid.
interface pixel_gen_pipe_if #(
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned CELL_LOG2 = 5,
  parameter int unsigned COLOR_W   = 12
);
  localparam int unsigned CUR_W = CNT_W - CELL_LOG2;

  logic               valid;
  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               frame_start;
  logic               enable_mouse_display;
  logic [COLOR_W-1:0] mouse_pixel;
  logic               enable_word_display;
  logic               word_pixel;
  logic               mem_pixel;
  logic               editing;
  logic [CUR_W-1:0]   writing_x;
  logic [CUR_W-1:0]   writing_y;
  logic               blink_en;
  logic               invert;
  logic [COLOR_W-1:0] pixel;
  logic               pixel_valid;

  modport master (
    output valid, h_cnt, v_cnt, frame_start, enable_mouse_display, mouse_pixel,
           enable_word_display, word_pixel, mem_pixel, editing, writing_x,
           writing_y, blink_en, invert,
    input  pixel, pixel_valid
  );

  modport slave (
    input  valid, h_cnt, v_cnt, frame_start, enable_mouse_display, mouse_pixel,
           enable_word_display, word_pixel, mem_pixel, editing, writing_x,
           writing_y, blink_en, invert,
    output pixel, pixel_valid
  );
endinterface

// File: rtl/pixel_gen_pipe.sv
// Two-stage registered pixel generator: cell grid, word layer, mouse sprite
// and a frame-counted blinking edit cursor, with an ink/background invert.
module pixel_gen_pipe #(
  parameter int unsigned        CNT_W         = 10,
  parameter int unsigned        CELL_LOG2     = 5,
  parameter int unsigned        COLOR_W       = 12,
  parameter int unsigned        BLINK_FRAMES  = 30,
  parameter logic [COLOR_W-1:0] FG_COLOR      = COLOR_W'(12'hfff),
  parameter logic [COLOR_W-1:0] BG_COLOR      = COLOR_W'(12'h000),
  parameter logic [COLOR_W-1:0] GRID_COLOR    = COLOR_W'(12'h333),
  parameter logic [COLOR_W-1:0] CUR_BORDER_ON = COLOR_W'(12'hccc)
) (
  input  logic              clk,
  input  logic              rst_n,
  pixel_gen_pipe_if.slave   bus
);

  localparam int unsigned CUR_W  = CNT_W - CELL_LOG2;
  localparam int unsigned BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic               valid;
    logic               border;
    logic               cur_hit;
    logic               mouse_en;
    logic [COLOR_W-1:0] mouse_pix;
    logic               mem;
    logic               word;
    logic               invert;
  } stage1_t;

  logic [BCNT_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               editing_q;
  stage1_t            s1_q, s1_d;
  logic [COLOR_W-1:0] pixel_q, pixel_d;
  logic               pixel_valid_q, pixel_valid_d;

  logic               edit_rise_c;
  logic               cursor_visible_c;
  logic [CELL_LOG2-1:0] h_lo_c, v_lo_c;
  logic [CUR_W-1:0]   h_cell_c, v_cell_c;
  logic [COLOR_W-1:0] ink_c, bg_c;

  // Blink counter: an editing rising edge restarts a visible half-period and
  // overrides any frame_start in the same cycle.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    edit_rise_c   = bus.editing & ~editing_q;
    if (edit_rise_c) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (bus.frame_start) begin
      if (blink_cnt_q == BCNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCNT_W'(1);
      end
    end
  end

  // Stage 1: cell geometry and cursor match, sampled with the pixel's inputs.
  always_comb begin
    h_lo_c           = bus.h_cnt[CELL_LOG2-1:0];
    v_lo_c           = bus.v_cnt[CELL_LOG2-1:0];
    h_cell_c         = bus.h_cnt[CNT_W-1:CELL_LOG2];
    v_cell_c         = bus.v_cnt[CNT_W-1:CELL_LOG2];
    cursor_visible_c = ~bus.blink_en | blink_phase_q;

    s1_d           = '0;
    s1_d.valid     = bus.valid;
    s1_d.border    = (&h_lo_c) | ~(|h_lo_c) | (&v_lo_c) | ~(|v_lo_c);
    s1_d.cur_hit   = bus.editing & cursor_visible_c &
                     (h_cell_c == bus.writing_x) & (v_cell_c == bus.writing_y);
    s1_d.mouse_en  = bus.enable_mouse_display;
    s1_d.mouse_pix = bus.mouse_pixel;
    s1_d.mem       = bus.mem_pixel;
    s1_d.word      = bus.word_pixel & bus.enable_word_display;
    s1_d.invert    = bus.invert;
  end

  // Stage 2: layer priority; grid and cursor-border colours ignore invert.
  always_comb begin
    ink_c         = s1_q.invert ? BG_COLOR : FG_COLOR;
    bg_c          = s1_q.invert ? FG_COLOR : BG_COLOR;
    pixel_d       = '0;
    pixel_valid_d = s1_q.valid;
    if (!s1_q.valid) begin
      pixel_d = '0;
    end else if (s1_q.mouse_en) begin
      pixel_d = s1_q.mouse_pix;
    end else if (s1_q.cur_hit && s1_q.border) begin
      pixel_d = s1_q.mem ? CUR_BORDER_ON : GRID_COLOR;
    end else if (s1_q.cur_hit) begin
      pixel_d = s1_q.mem ? ink_c : bg_c;
    end else if (s1_q.border) begin
      pixel_d = GRID_COLOR;
    end else if (s1_q.word) begin
      pixel_d = ink_c;
    end else begin
      pixel_d = bg_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      editing_q     <= 1'b0;
      s1_q          <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      editing_q     <= bus.editing;
      s1_q          <= s1_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_pixel_gen_pipe.sv
// Bench for pixel_gen_pipe: vector table plus blink and async-reset sequences,
// expected results queued at drive time and popped two edges later.
module tb_pixel_gen_pipe;

  logic clk;
  logic rst_n;

  pixel_gen_pipe_if #(.CNT_W(10), .CELL_LOG2(5), .COLOR_W(12)) bus ();

  pixel_gen_pipe #(
    .CNT_W(10), .CELL_LOG2(5), .COLOR_W(12), .BLINK_FRAMES(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [9:0]  h, v;
    logic        me;
    logic [11:0] mp;
    logic        we, wp, mem, ed;
    logic [4:0]  wx, wy;
    logic        be, inv, fs;
    logic [11:0] px;
    logic        pv;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [11:0] px;
    logic        pv;
    string       name;
  } exp_t;

  exp_t q[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(string n, logic valid, int h, int v, logic me,
                              logic [11:0] mp, logic we, logic wp, logic mem,
                              logic ed, int wx, int wy, logic inv,
                              logic [11:0] px, logic pv);
    vec_t x;
    x.name = n; x.valid = valid; x.h = 10'(h); x.v = 10'(v);
    x.me = me; x.mp = mp; x.we = we; x.wp = wp; x.mem = mem; x.ed = ed;
    x.wx = 5'(wx); x.wy = 5'(wy); x.be = 1'b0; x.inv = inv; x.fs = 1'b0;
    x.px = px; x.pv = pv;
    return x;
  endfunction

  task automatic check(input string n, input logic [11:0] px, input logic pv);
    n_vec++;
    if (bus.pixel !== px || bus.pixel_valid !== pv) begin
      n_err++;
      $display("FAIL %s: got pixel=%h valid=%b, want pixel=%h valid=%b",
               n, bus.pixel, bus.pixel_valid, px, pv);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.valid                = x.valid;
    bus.h_cnt                = x.h;
    bus.v_cnt                = x.v;
    bus.frame_start          = x.fs;
    bus.enable_mouse_display = x.me;
    bus.mouse_pixel          = x.mp;
    bus.enable_word_display  = x.we;
    bus.word_pixel           = x.wp;
    bus.mem_pixel            = x.mem;
    bus.editing              = x.ed;
    bus.writing_x            = x.wx;
    bus.writing_y            = x.wy;
    bus.blink_en             = x.be;
    bus.invert               = x.inv;
  endtask

  // One pixel clock: drive on the falling edge, check the result due now.
  task automatic apply(input vec_t x, input logic chk);
    exp_t e;
    @(negedge clk);
    drive(x);
    e.chk = chk; e.px = x.px; e.pv = x.pv; e.name = x.name;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      if (e.chk) check(e.name, e.px, e.pv);
    end
  endtask

  task automatic seed_after_reset();
    exp_t e;
    e.chk = 1'b1; e.px = 12'h000; e.pv = 1'b0; e.name = "post_rst_flush";
    q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500us");
    $fatal(1, "watchdog");
  end

  int bs_ed [22] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1,1,1};
  int bs_fs [22] = '{0,0,1,0,1,1,0,1,1,1,0,1,1,1,0,0,0,0,1,1,1,0};
  int bs_vis[22] = '{0,1,1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,1,1,1,1,0};

  initial begin
    vec_t b;
    rst_n = 1'b0;
    b = mk("idle", 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0);
    drive(b);

    //                name            vl  h     v    me  mp       we wp mem ed wx wy inv  px       pv
    tbl.push_back(mk("bg_interior",   1,  40,   40,  0,  12'h000, 0, 0, 0,  0, 0, 0, 0,  12'h000, 1));
    tbl.push_back(mk("border_h32",    1,  32,   40,  0,  12'h000, 0, 0, 0,  0, 0, 0, 0,  12'h333, 1));
    tbl.push_back(mk("border_h63",    1,  63,   40,  0,  12'h000, 0, 0, 0,  0, 0, 0, 0,  12'h333, 1));
    tbl.push_back(mk("border_v0",     1,  40,   0,   0,  12'h000, 0, 0, 0,  0, 0, 0, 0,  12'h333, 1));
    tbl.push_back(mk("border_v31",    1,  40,   31,  0,  12'h000, 0, 0, 0,  0, 0, 0, 0,  12'h333, 1));
    tbl.push_back(mk("border_max",    1,  1023, 1023,0,  12'h000, 0, 0, 0,  0, 0, 0, 0,  12'h333, 1));
    tbl.push_back(mk("word_ink",      1,  33,   40,  0,  12'h000, 1, 1, 0,  0, 0, 0, 0,  12'hfff, 1));
    tbl.push_back(mk("word_ink_inv",  1,  33,   40,  0,  12'h000, 1, 1, 0,  0, 0, 0, 1,  12'h000, 1));
    tbl.push_back(mk("bg_inv",        1,  33,   40,  0,  12'h000, 1, 0, 0,  0, 0, 0, 1,  12'hfff, 1));
    tbl.push_back(mk("word_gated",    1,  33,   40,  0,  12'h000, 0, 1, 0,  0, 0, 0, 0,  12'h000, 1));
    tbl.push_back(mk("border_inv",    1,  32,   40,  0,  12'h000, 1, 1, 0,  0, 0, 0, 1,  12'h333, 1));
    tbl.push_back(mk("cur_brd_on",    1,  32,   40,  0,  12'h000, 0, 0, 1,  1, 1, 1, 0,  12'hccc, 1));
    tbl.push_back(mk("cur_brd_off",   1,  32,   40,  0,  12'h000, 0, 0, 0,  1, 1, 1, 0,  12'h333, 1));
    tbl.push_back(mk("cur_int_on",    1,  40,   40,  0,  12'h000, 0, 0, 1,  1, 1, 1, 0,  12'hfff, 1));
    tbl.push_back(mk("cur_over_word", 1,  40,   40,  0,  12'h000, 1, 1, 0,  1, 1, 1, 0,  12'h000, 1));
    tbl.push_back(mk("cur_int_inv",   1,  40,   40,  0,  12'h000, 0, 0, 1,  1, 1, 1, 1,  12'h000, 1));
    tbl.push_back(mk("cur_brd_inv",   1,  32,   40,  0,  12'h000, 0, 0, 1,  1, 1, 1, 1,  12'hccc, 1));
    tbl.push_back(mk("cur_miss_x",    1,  40,   40,  0,  12'h000, 0, 0, 1,  1, 2, 1, 0,  12'h000, 1));
    tbl.push_back(mk("cur_noedit",    1,  40,   40,  0,  12'h000, 0, 0, 1,  0, 1, 1, 0,  12'h000, 1));
    tbl.push_back(mk("mouse_top",     1,  32,   40,  1,  12'hf00, 0, 0, 1,  1, 1, 1, 0,  12'hf00, 1));
    tbl.push_back(mk("mouse_invalid", 0,  32,   40,  1,  12'hf00, 0, 0, 1,  1, 1, 1, 0,  12'h000, 0));
    tbl.push_back(mk("invalid_word",  0,  33,   40,  0,  12'h000, 1, 1, 0,  0, 0, 0, 0,  12'h000, 0));

    repeat (3) @(posedge clk);
    #1 check("in_reset", 12'h000, 1'b0);
    #1 rst_n = 1'b1;
    seed_after_reset();

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // Blink with a 3-frame half-period on an interior cursor pixel (mem=1).
    for (int i = 0; i < 22; i++) begin
      b = mk($sformatf("blink_%0d", i), 1, 40, 40, 0, 12'h000, 0, 0, 1,
             logic'(bs_ed[i]), 1, 1, 0, bs_vis[i] != 0 ? 12'hfff : 12'h000, 1);
      b.be = 1'b1;
      b.fs = logic'(bs_fs[i]);
      apply(b, 1'b1);
    end

    // Cursor is now hidden; put a mouse pixel on the output, then reset between edges.
    b = mk("pre_rst_mouse", 1, 40, 40, 1, 12'h0f0, 0, 0, 1, 1, 1, 1, 0, 12'h0f0, 1);
    b.be = 1'b1;
    apply(b, 1'b1);
    apply(b, 1'b1);
    check("pre_rst_out", 12'h0f0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 12'h000, 1'b0);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seed_after_reset();

    b = mk("post_rst_visible", 1, 40, 40, 0, 12'h000, 0, 0, 1, 1, 1, 1, 0, 12'hfff, 1);
    b.be = 1'b1;
    apply(b, 1'b1);
    apply(b, 1'b1);
    b = mk("flush", 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0);
    apply(b, 1'b1);
    apply(b, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
